ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 byte receiver. Consumes the receiver's raw byte, valid and error outputs, which are generated in the ps2_clk domain.
- Synchronizes those outputs into the system clock domain and decodes Set-2 prefix sequences (E0 extended, F0 break, E1 pause).
- Queues complete key events in a small first-word-fall-through FIFO, drained by the CPU-side peripheral bus with a ready/valid handshake.

Parameters:
- FIFO_DEPTH, 8, key-event FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages synchronizing ps2_valid_in; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ps2_data_in  input  8  byte from receiver; stable while ps2_valid_in is high
- ps2_valid_in  input  1  receiver valid level (ps2_clk domain); a rising edge means a new byte
- ps2_err_in  input  1  receiver parity error; qualifies the same byte
- key_code  output  8  scancode of the head event
- key_ext  output  1  head event had an E0 prefix
- key_break  output  1  head event is a release (F0 prefix)
- key_valid  output  1  FIFO non-empty
- key_ready  input  1  consumer pop; an event is popped when key_valid && key_ready
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- frame_err  output  1  sticky: a byte arrived with ps2_err_in set
- clr_sticky  input  1  clears overflow and frame_err

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - synchronizer flops 0
  - FIFO empty
- Byte capture:
  - ps2_valid_in passes through SYNC_STAGES flops; a 0->1 edge on the last stage produces a one-cycle byte strobe.
  - On the strobe, ps2_data_in and ps2_err_in are registered. They are stable at that point because the receiver holds them with valid.
- Latency: from the first clk edge that samples ps2_valid_in=1 with an empty FIFO, key_valid rises exactly SYNC_STAGES+2 clocks later.
- Error byte (captured err=1), in any state:
  - set frame_err
  - discard the byte
  - FSM -> IDLE
  - push nothing
- Decoder FSM, on each good byte:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> PAUSE with skip counter = 7
    - 00, AA, EE, FA, FC, FE, FF: discarded as status bytes, stay in IDLE
    - any other byte: push {code, ext=0, brk=0}, stay in IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> stay in EXT
    - any other byte: push {code, 1, 0}, -> IDLE
  - BRK:
    - F0 or E0: ignored, stay in BRK
    - any other byte: push {code, 0, 1}, -> IDLE
  - EXT_BRK:
    - F0: ignored, stay
    - any other byte: push {code, 1, 1}, -> IDLE
  - PAUSE:
    - every good byte decrements the counter
    - when the counter reaches 0: push {E1, 1, 0}, -> IDLE
- FIFO:
  - First-word fall-through: key_code, key_ext and key_break are valid whenever key_valid=1 and are held until popped.
  - Push while full without a simultaneous pop: the new event is dropped, overflow is set, and contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: only the push occurs. The head is not visible until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - key_ready while empty: ignored.
- Sticky bits:
  - clr_sticky clears both bits on the next clock edge.
  - If a set condition occurs in the same cycle as clr_sticky, the set wins.
- Reset mid-sequence: any partial prefix is abandoned and the FIFO is flushed.

Optional Feature:
- Macro: PS2_ASCII_EN.
- When defined:
  - Adds output key_ascii [7:0], registered alongside each FIFO entry.
  - Translates make and break events of non-extended Set-2 letter, digit, space and enter codes to lowercase ASCII through an internal case ROM.
  - Tracks shift state from codes 12 and 59; while either is held, letters are uppercase.
  - Untranslatable codes and all extended codes give key_ascii=00.
- When undefined: no port, no ROM, no shift tracking.

Test Plan:
- Byte 1C, then valid drop, then byte F0, then byte 1C -> two events {1C,0,0} and {1C,0,1}; first key_valid exactly SYNC_STAGES+2 clocks after valid is sampled.
- Bytes E0 75, then E0 F0 75 -> events {75,1,0} and {75,1,1}.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}, no other events.
- Byte with ps2_err_in=1 in the middle of E0 F0 -> frame_err=1, FSM returns to IDLE; the following byte 1C -> {1C,0,0}.
- With key_ready=0, push FIFO_DEPTH+1 make codes -> fifo_count=FIFO_DEPTH, overflow=1, head is the first code. Then clr_sticky -> overflow=0, and with key_ready held high the codes drain in order.
- Assert rst_n low while in EXT with 3 events queued -> all outputs 0 immediately. After release, byte 75 -> {75,0,0}.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: synchronizes receiver bytes, decodes E0/F0/E1 prefixes, queues key events in a FWFT FIFO.
// Optional macro PS2_ASCII_EN adds key_ascii with shift-aware ASCII translation.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    ps2_data_in,
  input  logic                          ps2_valid_in,
  input  logic                          ps2_err_in,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_sticky
`ifdef PS2_ASCII_EN
  ,
  output logic [7:0]                    key_ascii
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   vlast_q, vlast_d;
  logic                   strobe;
  logic                   byte_vld_q, byte_vld_d;
  logic [7:0]             byte_q, byte_d;
  logic                   err_q, err_d;

  state_t                 state_q, state_d;
  logic [2:0]             skip_q, skip_d;
  logic                   push_q, push_d;
  logic [7:0]             push_code_q, push_code_d;
  logic                   push_ext_q, push_ext_d;
  logic                   push_brk_q, push_brk_d;
  logic                   frame_set;
  logic                   is_status;

  logic [7:0]             code_mem [FIFO_DEPTH];
  logic                   ext_mem  [FIFO_DEPTH];
  logic                   brk_mem  [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full, pop, wr_en, ovf_set;
  logic                   overflow_q, overflow_d, frame_err_q, frame_err_d;

`ifdef PS2_ASCII_EN
  logic [7:0] push_ascii_q, push_ascii_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [7:0] ascii_mem [FIFO_DEPTH];

  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic upper);
    logic [7:0] a;
    case (c)
      8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
      8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
      8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
      8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
      8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
      8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
      8'h35: a = "y"; 8'h1A: a = "z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
      8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
      8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    if (upper && a >= "a" && a <= "z") a = a - 8'h20;
    return a;
  endfunction
`endif

  // Byte strobe on a rising edge of the synchronized valid level
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ps2_valid_in};
    vlast_d    = sync_q[SYNC_STAGES-1];
    strobe     = sync_q[SYNC_STAGES-1] & ~vlast_q;
    byte_vld_d = strobe;
    byte_d     = strobe ? ps2_data_in : byte_q;
    err_d      = strobe ? ps2_err_in  : err_q;
    is_status  = byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  end

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    push_d      = 1'b0;
    push_code_d = byte_q;
    push_ext_d  = 1'b0;
    push_brk_d  = 1'b0;
    frame_set   = 1'b0;
    if (byte_vld_q) begin
      if (err_q) begin
        frame_set = 1'b1;
        state_d   = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_q == 8'hE0)      state_d = S_EXT;
            else if (byte_q == 8'hF0) state_d = S_BRK;
            else if (byte_q == 8'hE1) begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end else if (!is_status)  push_d = 1'b1;
          end
          S_EXT: begin
            if (byte_q == 8'hF0)      state_d = S_EXT_BRK;
            else if (byte_q != 8'hE0) begin
              push_d     = 1'b1;
              push_ext_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
          S_BRK: begin
            if (byte_q != 8'hF0 && byte_q != 8'hE0) begin
              push_d     = 1'b1;
              push_brk_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if (byte_q != 8'hF0) begin
              push_d     = 1'b1;
              push_ext_d = 1'b1;
              push_brk_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
          S_PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              push_d      = 1'b1;
              push_code_d = 8'hE1;
              push_ext_d  = 1'b1;
              state_d     = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_ASCII_EN
  // Shift state follows non-extended make/break of left (12) and right (59) shift
  always_comb begin
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    push_ascii_d = 8'h00;
    if (push_d && !push_ext_d) begin
      push_ascii_d = to_ascii(push_code_d, shift_l_q | shift_r_q);
      if (push_code_d == 8'h12) shift_l_d = ~push_brk_d;
      if (push_code_d == 8'h59) shift_r_d = ~push_brk_d;
    end
  end
`endif

  always_comb begin
    full        = (count_q == CW'(FIFO_DEPTH));
    pop         = key_valid & key_ready;
    wr_en       = push_q & (~full | pop);
    ovf_set     = push_q & full & ~pop;
    wr_ptr_d    = wr_ptr_q + AW'(wr_en);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(wr_en) - CW'(pop);
    overflow_d  = (overflow_q  & ~clr_sticky) | ovf_set;
    frame_err_d = (frame_err_q & ~clr_sticky) | frame_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      vlast_q      <= 1'b0;
      byte_vld_q   <= 1'b0;
      byte_q       <= '0;
      err_q        <= 1'b0;
      state_q      <= S_IDLE;
      skip_q       <= '0;
      push_q       <= 1'b0;
      push_code_q  <= '0;
      push_ext_q   <= 1'b0;
      push_brk_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_ASCII_EN
      push_ascii_q <= '0;
      shift_l_q    <= 1'b0;
      shift_r_q    <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      vlast_q      <= vlast_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      err_q        <= err_d;
      state_q      <= state_d;
      skip_q       <= skip_d;
      push_q       <= push_d;
      push_code_q  <= push_code_d;
      push_ext_q   <= push_ext_d;
      push_brk_q   <= push_brk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_ASCII_EN
      push_ascii_q <= push_ascii_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      code_mem[wr_ptr_q]  <= push_code_q;
      ext_mem[wr_ptr_q]   <= push_ext_q;
      brk_mem[wr_ptr_q]   <= push_brk_q;
`ifdef PS2_ASCII_EN
      ascii_mem[wr_ptr_q] <= push_ascii_q;
`endif
    end
  end

  // Head fields are gated so outputs read 0 while the FIFO is empty
  always_comb begin
    key_valid  = (count_q != '0);
    key_code   = key_valid ? code_mem[rd_ptr_q] : '0;
    key_ext    = key_valid & ext_mem[rd_ptr_q];
    key_break  = key_valid & brk_mem[rd_ptr_q];
    fifo_count = count_q;
    overflow   = overflow_q;
    frame_err  = frame_err_q;
`ifdef PS2_ASCII_EN
    key_ascii  = key_valid ? ascii_mem[rd_ptr_q] : '0;
`endif
  end

endmodule
